// File: rtl/dii_header_strip_if.sv
// DI flit channel: forward flit {valid,last,data[15:0]} and backward ready.
// master drives the flit, slave drives ready.
interface dii_header_strip_if;
  logic [17:0] flit;
  logic        ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);
endinterface

// File: rtl/dii_header_strip.sv
// Strips the header flits of DI packets, latches dest/src/flags on a sideband and
// forwards the payload through one output register, optionally merging event chains.
module dii_header_strip #(
  parameter int                 HDR_WORDS    = 3,
  parameter int                 MERGE_EVENTS = 1,
  parameter int                 EVT_LSB      = 10,
  parameter int                 EVT_W        = 4,
  parameter logic [EVT_W-1:0]   CONT_CODE    = 'h1,
  parameter int                 CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dii_header_strip_if.slave  in_ch,
  dii_header_strip_if.master out_ch,
  output logic [15:0]        hdr_dest,
  output logic [15:0]        hdr_src,
  output logic [15:0]        hdr_flags,
  output logic               hdr_valid,
  output logic               chain_open,
  output logic               hdr_err,
  output logic [CNT_W-1:0]   pkt_cnt
);

  localparam int IDX_W = $clog2(HDR_WORDS);

  typedef enum logic {HDR, PAYLOAD} state_t;

  state_t           state;
  logic [IDX_W-1:0] hdr_idx;
  logic             last_evt;
  logic             out_valid;
  logic             out_last;
  logic [15:0]      out_data;

  logic        in_valid;
  logic        in_last;
  logic [15:0] in_data;
  logic        accept;
  logic        idx_final;
  logic        evt_last;
  logic        merge_last;
  logic        out_last_taken;

  assign in_valid = in_ch.flit[17];
  assign in_last  = in_ch.flit[16];
  assign in_data  = in_ch.flit[15:0];

  // Header flits never touch the output register, so they are always accepted.
  assign in_ch.ready = (state == HDR) | ~out_valid | out_ch.ready;
  assign accept      = in_valid & in_ch.ready;

  assign out_ch.flit = {out_valid, out_last, out_data};

  assign idx_final      = (hdr_idx == IDX_W'(HDR_WORDS - 1));
  assign evt_last       = (in_data[EVT_LSB +: EVT_W] != CONT_CODE);
  assign merge_last     = (MERGE_EVENTS != 0) ? last_evt : 1'b1;
  assign out_last_taken = out_valid & out_last & out_ch.ready;

  // Packet FSM, header sideband, output register and packet counter.
  // A chain opened by a new flags word wins over a chain closing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      hdr_idx    <= '0;
      last_evt   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      hdr_dest   <= '0;
      hdr_src    <= '0;
      hdr_flags  <= '0;
      hdr_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      chain_open <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      hdr_valid <= 1'b0;
      hdr_err   <= 1'b0;
      if (out_ch.ready) out_valid <= 1'b0;
      if (out_last_taken) chain_open <= 1'b0;

      case (state)
        HDR: begin
          if (in_valid) begin
            if (in_last && !idx_final) begin
              hdr_err <= 1'b1;
              hdr_idx <= '0;
            end else begin
              if (hdr_idx == IDX_W'(0)) hdr_dest <= in_data;
              if (hdr_idx == IDX_W'(1)) hdr_src  <= in_data;
              if (hdr_idx == IDX_W'(2)) begin
                hdr_flags <= in_data;
                hdr_valid <= 1'b1;
                last_evt  <= evt_last;
                if ((MERGE_EVENTS != 0) && !evt_last) chain_open <= 1'b1;
              end
              if (idx_final) begin
                hdr_idx <= '0;
                if (in_last) begin
                  if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
                end else begin
                  state <= PAYLOAD;
                end
              end else begin
                hdr_idx <= hdr_idx + 1'b1;
              end
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last & merge_last;
            if (in_last) begin
              state <= HDR;
              if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            end
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_dii_header_strip.sv
// Self-checking bench: three stripper instances (default, no merging, 4-word header with
// 2-bit counter) driven from per-instance packet queues and checked against a packet-level model.
module tb_dii_header_strip;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] inflit   [3];
  logic        inready  [3];
  logic        outready [3];
  logic [17:0] outflit  [3];
  logic [15:0] hdest    [3];
  logic [15:0] hsrc     [3];
  logic [15:0] hflags   [3];
  logic        hvalid   [3];
  logic        herr     [3];
  logic        copen    [3];
  logic [15:0] pcnt     [3];

  logic [17:0] txq   [3][$];
  logic [16:0] expq  [3][$];
  logic [47:0] hdrq  [3][$];
  bit          pres  [3];
  int          mcnt  [3];
  int          merr  [3];
  bit          lastEvtM [3];
  int          errCnt [3];
  int          hvCnt  [3];
  int          xfer   [3];
  logic [16:0] lastSeen [3];

  int validPct = 100;
  int stallPct = 0;
  int passCnt  = 0;
  int totalCnt = 0;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int HW = (g == 2) ? 4 : 3;
    localparam int MG = (g == 1) ? 0 : 1;
    localparam int CW = (g == 2) ? 2 : 16;

    dii_header_strip_if in_ch ();
    dii_header_strip_if out_ch ();
    logic [CW-1:0] cnt;

    assign in_ch.flit   = inflit[g];
    assign inready[g]   = in_ch.ready;
    assign out_ch.ready = outready[g];
    assign outflit[g]   = out_ch.flit;
    assign pcnt[g]      = 16'(cnt);

    dii_header_strip #(.HDR_WORDS(HW), .MERGE_EVENTS(MG), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_ch      (in_ch),
      .out_ch     (out_ch),
      .hdr_dest   (hdest[g]),
      .hdr_src    (hsrc[g]),
      .hdr_flags  (hflags[g]),
      .hdr_valid  (hvalid[g]),
      .chain_open (copen[g]),
      .hdr_err    (herr[g]),
      .pkt_cnt    (cnt)
    );

    // Upstream driver: holds a presented flit until it is accepted.
    initial begin
      bit fire;
      forever begin
        @(negedge clk);
        fire = pres[g] && inready[g];
        @(posedge clk);
        #1;
        if (!rst_n) begin
          pres[g]     = 1'b0;
          inflit[g]   = '0;
          outready[g] = 1'b1;
          continue;
        end
        if (fire && txq[g].size() > 0) begin
          void'(txq[g].pop_front());
          pres[g] = 1'b0;
        end
        if (!pres[g] && txq[g].size() > 0 && $urandom_range(99) < validPct) pres[g] = 1'b1;
        inflit[g]   = pres[g] ? txq[g][0] : 18'h0;
        outready[g] = ($urandom_range(99) >= stallPct);
      end
    end

    // Compare process: transfers, held data under stall, header sideband.
    initial begin
      bit          held;
      logic [16:0] heldVal;
      held = 1'b0;
      heldVal = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          held = 1'b0;
          continue;
        end
        if (held) checkOutput($sformatf("stall_hold%0d", g), 48'(outflit[g]), 48'({1'b1, heldVal}));
        if (outflit[g][17] && outready[g]) begin
          if (expq[g].size() == 0) checkOutput($sformatf("spurious_flit%0d", g), 48'(outflit[g]), 48'h0);
          else checkOutput($sformatf("out_flit%0d", g), 48'(outflit[g][16:0]), 48'(expq[g].pop_front()));
          lastSeen[g] = outflit[g][16:0];
          xfer[g]++;
        end
        held    = outflit[g][17] && !outready[g];
        heldVal = outflit[g][16:0];
        if (hvalid[g]) begin
          hvCnt[g]++;
          if (hdrq[g].size() == 0) checkOutput($sformatf("spurious_hdr%0d", g), {hdest[g], hsrc[g], hflags[g]}, 48'h0);
          else checkOutput($sformatf("hdr%0d", g), {hdest[g], hsrc[g], hflags[g]}, hdrq[g].pop_front());
        end
        if (herr[g]) errCnt[g]++;
      end
    end
  end

  function automatic int cntMax(input int g);
    return (g == 2) ? 3 : 65535;
  endfunction

  // Queues one packet for instance g and predicts its effect from the packet rules:
  // errPos >= 0 puts 'last' on that header word.
  task automatic applyStimulus(input int g, input logic [15:0] dest, input logic [15:0] src,
                               input logic [15:0] flags, input int npay, input int errPos,
                               input logic [15:0] payBase);
    int          hw;
    bit          mg;
    logic [15:0] w;
    bit          lb;
    hw = (g == 2) ? 4 : 3;
    mg = (g != 1);
    for (int p = 0; p < hw; p++) begin
      w  = (p == 0) ? dest : (p == 1) ? src : (p == 2) ? flags : 16'($urandom);
      lb = (p == errPos);
      txq[g].push_back({1'b1, lb, w});
      if (lb && p < hw - 1) begin
        merr[g]++;
        return;
      end
      if (p == 2) begin
        hdrq[g].push_back({dest, src, flags});
        lastEvtM[g] = (flags[13:10] != 4'h1);
      end
      if (lb) begin
        if (mcnt[g] < cntMax(g)) mcnt[g]++;
        return;
      end
    end
    for (int i = 0; i < npay; i++) begin
      lb = (i == npay - 1);
      w  = payBase + 16'(i);
      txq[g].push_back({1'b1, lb, w});
      expq[g].push_back({lb && (mg ? lastEvtM[g] : 1'b1), w});
    end
    if (mcnt[g] < cntMax(g)) mcnt[g]++;
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int n;
    int left;
    n = 0;
    forever begin
      left = 0;
      for (int g = 0; g < 3; g++) left += txq[g].size() + expq[g].size() + int'(pres[g]);
      if (left == 0 || n >= maxCyc) break;
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput(name, 48'(left), 48'h0);
  endtask

  task automatic clearModel();
    for (int g = 0; g < 3; g++) begin
      txq[g].delete();
      expq[g].delete();
      hdrq[g].delete();
      mcnt[g] = 0;
      merr[g] = 0;
      lastEvtM[g] = 1'b1;
      errCnt[g] = 0;
      hvCnt[g] = 0;
      xfer[g] = 0;
      lastSeen[g] = '0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int hw;
    int r;
    int ep;
    logic [15:0] flags;

    for (int g = 0; g < 3; g++) begin
      inflit[g]   = '0;
      outready[g] = 1'b1;
      pres[g]     = 1'b0;
    end
    clearModel();

    // Reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checkOutput("rst_out_flit", 48'(outflit[g]), 48'h0);
      checkOutput("rst_hdr", {hdest[g], hsrc[g], hflags[g]}, 48'h0);
      checkOutput("rst_pulses", {45'h0, hvalid[g], herr[g], copen[g]}, 48'h0);
      checkOutput("rst_pkt_cnt", 48'(pcnt[g]), 48'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single packet {5,0x10,0,A,B,C}
    applyStimulus(0, 16'h0005, 16'h0010, 16'h0000, 3, -1, 16'h000A);
    waitDrain("drain_single", 200);
    checkOutput("single_dest", 48'(hdest[0]), 48'h5);
    checkOutput("single_src", 48'(hsrc[0]), 48'h10);
    checkOutput("single_cnt", 48'(pcnt[0]), 48'h1);
    checkOutput("single_hv_pulses", 48'(hvCnt[0]), 48'h1);
    checkOutput("single_xfers", 48'(xfer[0]), 48'h3);
    checkOutput("single_last_C", 48'(lastSeen[0]), 48'h1000C);

    // Event chain: continuation packet then closing packet, merged on inst 0, not on inst 1
    for (int g = 0; g < 2; g++) begin
      applyStimulus(g, 16'h0001, 16'h0002, 16'h0400, 2, -1, 16'h0100);
      applyStimulus(g, 16'h0003, 16'h0004, 16'h0000, 1, -1, 16'h0200);
    end
    n = 0;
    while (xfer[0] < 5 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("chain_open_mid", 48'(copen[0]), 48'h1);
    checkOutput("chain_Y_no_last", 48'(lastSeen[0]), 48'h00101);
    checkOutput("chain_open_nomerge", 48'(copen[1]), 48'h0);
    waitDrain("drain_chain", 200);
    checkOutput("chain_closed", 48'(copen[0]), 48'h0);
    checkOutput("chain_Z_last", 48'(lastSeen[0]), 48'h10200);
    checkOutput("nomerge_Z_last", 48'(lastSeen[1]), 48'h10200);

    // Last on second header flit, then a clean packet
    applyStimulus(0, 16'h0007, 16'h0008, 16'h0000, 0, 1, 16'h0000);
    applyStimulus(0, 16'h0011, 16'h0012, 16'h0000, 2, -1, 16'h0300);
    waitDrain("drain_err", 200);
    checkOutput("err_pulses", 48'(errCnt[0]), 48'h1);
    checkOutput("err_cnt_unchanged", 48'(pcnt[0]), 48'h4);
    checkOutput("err_next_pkt", 48'(lastSeen[0]), 48'h10301);

    // 4-word header, 2-bit counter: five packets saturate the count at 3
    for (int k = 0; k < 5; k++)
      applyStimulus(2, 16'h0020 + 16'(k), 16'h0030, 16'h0000, 2, -1, 16'h0400 + 16'(k * 16));
    waitDrain("drain_sat", 300);
    checkOutput("sat_cnt", 48'(pcnt[2]), 48'h3);
    checkOutput("sat_xfers", 48'(xfer[2]), 48'hA);
    checkOutput("sat_last", 48'(lastSeen[2]), 48'h10441);

    // Randomized traffic with 30% downstream stalls
    validPct = 80;
    stallPct = 30;
    for (int k = 0; k < 200; k++) begin
      for (int g = 0; g < 3; g++) begin
        hw = (g == 2) ? 4 : 3;
        r  = int'($urandom_range(99));
        ep = (r < 8) ? int'($urandom_range(hw - 2)) : (r < 12) ? hw - 1 : -1;
        flags = 16'($urandom) & 16'hC3FF;
        if ($urandom_range(9) < 3) flags = flags | 16'h0400;
        else if ($urandom_range(1) == 1) flags = flags | 16'h0800;
        applyStimulus(g, 16'($urandom), 16'($urandom), flags, int'($urandom_range(1, 6)), ep, 16'($urandom));
      end
    end
    waitDrain("drain_random", 30000);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("rand_cnt%0d", g), 48'(pcnt[g]), 48'(mcnt[g]));
      checkOutput($sformatf("rand_err%0d", g), 48'(errCnt[g]), 48'(merr[g]));
      checkOutput($sformatf("rand_hdr_left%0d", g), 48'(hdrq[g].size()), 48'h0);
    end

    // Reset while a payload flit is held in the output register
    validPct = 100;
    stallPct = 100;
    applyStimulus(0, 16'h0050, 16'h0051, 16'h0000, 4, -1, 16'h0500);
    n = 0;
    while (!outflit[0][17] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_before_reset", 48'(outflit[0][17]), 48'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 48'(outflit[0][17]), 48'h0);
    checkOutput("reset_cnt", 48'(pcnt[0]), 48'h0);
    checkOutput("reset_chain", 48'(copen[0]), 48'h0);
    clearModel();
    stallPct = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) applyStimulus(g, 16'h0060, 16'h0061, 16'h0000, 2, -1, 16'h0600);
    waitDrain("drain_after_reset", 200);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("post_reset_cnt%0d", g), 48'(pcnt[g]), 48'h1);
      checkOutput($sformatf("post_reset_last%0d", g), 48'(lastSeen[g]), 48'h10601);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
